// File: rtl/trap_flag_ctrl_pkg.sv
// trap_flag_ctrl_pkg: shared trap codes, vector base and FSM encoding for the trap-flag controller
// Contents:
//   TRAP_NONE/OVF/PDL/BOTH  trap code constants, encoded as {TRAP2,TRAP1}
//   TRAP_VECT_BASE          default trap vector base (octal 420)
//   state_t                 handshake FSM states IDLE/REQ
package trap_flag_ctrl_pkg;
   localparam logic [1:0] TRAP_NONE = 2'd0;
   localparam logic [1:0] TRAP_OVF  = 2'd1;
   localparam logic [1:0] TRAP_PDL  = 2'd2;
   localparam logic [1:0] TRAP_BOTH = 2'd3;
   localparam logic [8:0] TRAP_VECT_BASE = 9'o420;
   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
endpackage

// File: rtl/trap_flag_cnt.sv
// trap_flag_cnt: saturating count of traps taken
// Ports:
//   clk    CPU clock
//   rst_n  synchronous active-low reset
//   inc_i  one-cycle increment strobe (accepted trap acknowledge)
//   cnt_o  count, sticks at all-ones
module trap_flag_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/trap_flag_ctrl.sv
// trap_flag_ctrl: accumulates TRAP1/TRAP2 flags, arbitrates trap entry and runs the microcode handshake
// Optional feature macro: TRAP_FLAG_CNT_EN (saturating trap-taken counter on trapCNT; 0 otherwise)
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   setTRAP1, setTRAP2    overflow event pulses
//   loadFLAGS, flagsIN    flag restore strobe and restored {TRAP2,TRAP1}
//   flagTRAPEN, consTRAPEN  APR and console trap enables
//   niBOUND               instruction-boundary strobe
//   trapACK               microcode entered the trap cycle
//   flagTRAP2, flagTRAP1  PC flag bits 9 and 10
//   trapREQ, trapVECT     pending trap request and its vector
//   trapCNT               traps taken (feature only)
module trap_flag_ctrl
   import trap_flag_ctrl_pkg::*;
#(
   parameter logic [8:0] VECT_BASE = TRAP_VECT_BASE,
   parameter int         CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 setTRAP1,
   input  logic                 setTRAP2,
   input  logic                 loadFLAGS,
   input  logic [1:0]           flagsIN,
   input  logic                 flagTRAPEN,
   input  logic                 consTRAPEN,
   input  logic                 niBOUND,
   input  logic                 trapACK,
   output logic                 flagTRAP2,
   output logic                 flagTRAP1,
   output logic                 trapREQ,
   output logic [8:0]           trapVECT,
   output logic [CNT_WIDTH-1:0] trapCNT
);
   state_t     state_q, state_d;
   logic [1:0] flags_q, flags_d, code_q, code_d, clr;
   logic [8:0] vect_q, vect_d;
   logic       ack, start;
   always_comb begin
      ack     = (state_q == REQ) && trapACK;
      // capture looks only at registered flags, so a same-cycle set waits for the next boundary
      start   = (state_q == IDLE) && niBOUND && flagTRAPEN && consTRAPEN && (flags_q != TRAP_NONE);
      // only the bits latched at capture are cleared; later sets survive the ack
      clr     = ack ? code_q : TRAP_NONE;
      flags_d = loadFLAGS ? flagsIN : (flags_q & ~clr) | {setTRAP2, setTRAP1};
      code_d  = start ? flags_q : code_q;
      vect_d  = start ? VECT_BASE + {7'd0, flags_q} : vect_q;
      state_d = start ? REQ : ack ? IDLE : state_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         flags_q <= TRAP_NONE;
         code_q  <= TRAP_NONE;
         vect_q  <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         code_q  <= code_d;
         vect_q  <= vect_d;
      end
   end
   assign flagTRAP2 = flags_q[1];
   assign flagTRAP1 = flags_q[0];
   assign trapREQ   = (state_q == REQ);
   assign trapVECT  = vect_q;
`ifdef TRAP_FLAG_CNT_EN
   trap_flag_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (ack),
      .cnt_o (trapCNT)
   );
`else
   assign trapCNT = '0;
`endif
endmodule

// File: tb/tb_trap_flag_ctrl.sv
// tb_trap_flag_ctrl: scoreboard bench for trap_flag_ctrl, directed scenarios plus random traffic
module tb_trap_flag_ctrl;
   localparam int CW = 2;
   localparam logic [8:0] VB = 9'o420;
   logic clk = 1'b0;
   logic rst_n, setTRAP1, setTRAP2, loadFLAGS, flagTRAPEN, consTRAPEN, niBOUND, trapACK;
   logic [1:0] flagsIN;
   logic flagTRAP2, flagTRAP1, trapREQ;
   logic [8:0] trapVECT;
   logic [CW-1:0] trapCNT;
   typedef struct packed {
      logic          f2;
      logic          f1;
      logic          req;
      logic [8:0]    vect;
      logic [CW-1:0] cnt;
   } exp_t;
   exp_t sb[$];
   int n_vec = 0;
   int n_bad = 0;
   logic [1:0]    m_f, m_code;
   logic          m_req;
   logic [8:0]    m_vect;
   logic [CW-1:0] m_cnt;
   trap_flag_ctrl #(.VECT_BASE(VB), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .setTRAP1(setTRAP1), .setTRAP2(setTRAP2),
      .loadFLAGS(loadFLAGS), .flagsIN(flagsIN), .flagTRAPEN(flagTRAPEN),
      .consTRAPEN(consTRAPEN), .niBOUND(niBOUND), .trapACK(trapACK),
      .flagTRAP2(flagTRAP2), .flagTRAP1(flagTRAP1), .trapREQ(trapREQ),
      .trapVECT(trapVECT), .trapCNT(trapCNT)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic cyc();
      exp_t e;
      logic ack, start;
      logic [1:0] clr, old_f;
      if (!rst_n) begin
         m_f = 0; m_code = 0; m_req = 0; m_vect = 0; m_cnt = 0;
      end else begin
         old_f = m_f;
         ack   = m_req && trapACK;
         start = !m_req && niBOUND && flagTRAPEN && consTRAPEN && old_f != 2'b00;
         clr   = ack ? m_code : 2'b00;
         if (loadFLAGS) m_f = flagsIN;
         else m_f = (old_f & ~clr) | {setTRAP2, setTRAP1};
         if (start) begin
            m_code = old_f;
            m_vect = VB + 9'(old_f);
            m_req  = 1'b1;
         end else if (ack) m_req = 1'b0;
`ifdef TRAP_FLAG_CNT_EN
         if (ack && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
      end
      e = '{f2: m_f[1], f1: m_f[0], req: m_req, vect: m_vect, cnt: m_cnt};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
         e = sb.pop_front();
         chk("flagTRAP2", flagTRAP2, e.f2);
         chk("flagTRAP1", flagTRAP1, e.f1);
         chk("trapREQ", trapREQ, e.req);
         chk("trapVECT", trapVECT, e.vect);
         chk("trapCNT", trapCNT, e.cnt);
      end
      setTRAP1 = 0; setTRAP2 = 0; loadFLAGS = 0; niBOUND = 0; trapACK = 0;
   endtask
   initial begin
      rst_n = 0; setTRAP1 = 0; setTRAP2 = 0; loadFLAGS = 0; flagsIN = 0;
      flagTRAPEN = 1; consTRAPEN = 1; niBOUND = 0; trapACK = 0;
      m_f = 0; m_code = 0; m_req = 0; m_vect = 0; m_cnt = 0;
      #2;
      cyc(); cyc();
      chk("rst_req", trapREQ, 0);
      chk("rst_vect", trapVECT, 0);
      rst_n = 1;
      setTRAP1 = 1; cyc();
      chk("t1_flag", flagTRAP1, 1);
      niBOUND = 1; cyc();
      chk("t1_req", trapREQ, 1);
      chk("t1_vect", trapVECT, 9'o421);
      niBOUND = 1; cyc();
      trapACK = 1; cyc();
      chk("t1_clr", flagTRAP1, 0);
      chk("t1_reqoff", trapREQ, 0);
      chk("t1_vhold", trapVECT, 9'o421);
      trapACK = 1; cyc();
      setTRAP1 = 1; setTRAP2 = 1; cyc();
      niBOUND = 1; cyc();
      chk("t2_vect", trapVECT, 9'o423);
      setTRAP2 = 1; trapACK = 1; cyc();
      chk("t2_late2", flagTRAP2, 1);
      chk("t2_late1", flagTRAP1, 0);
      niBOUND = 1; cyc();
      chk("t2_vect2", trapVECT, 9'o422);
      trapACK = 1; cyc();
      consTRAPEN = 0; setTRAP2 = 1; cyc();
      niBOUND = 1; cyc();
      chk("t3_gated", trapREQ, 0);
      chk("t3_flag", flagTRAP2, 1);
      consTRAPEN = 1; niBOUND = 1; cyc();
      chk("t3_vect", trapVECT, 9'o422);
      flagTRAPEN = 0; cyc();
      chk("t3_noretract", trapREQ, 1);
      trapACK = 1; cyc();
      flagTRAPEN = 1;
      loadFLAGS = 1; flagsIN = 2'b01; setTRAP2 = 1; cyc();
      chk("t4_f2drop", flagTRAP2, 0);
      chk("t4_f1", flagTRAP1, 1);
      niBOUND = 1; cyc();
      loadFLAGS = 1; flagsIN = 2'b11; cyc();
      trapACK = 1; cyc();
      chk("t4_ldack2", flagTRAP2, 1);
      chk("t4_ldack1", flagTRAP1, 0);
      loadFLAGS = 1; flagsIN = 2'b00; cyc();
      setTRAP1 = 1; niBOUND = 1; cyc();
      chk("t4_samecyc", trapREQ, 0);
      niBOUND = 1; cyc();
      chk("t4_nextbound", trapREQ, 1);
      rst_n = 0; cyc();
      chk("t5_req", trapREQ, 0);
      chk("t5_flag", flagTRAP1, 0);
      chk("t5_vect", trapVECT, 0);
      rst_n = 1; trapACK = 1; cyc();
      chk("t5_ackign", trapREQ, 0);
      for (int i = 0; i < 5; i++) begin
         setTRAP1 = 1; cyc();
         niBOUND = 1; cyc();
         trapACK = 1; cyc();
      end
`ifdef TRAP_FLAG_CNT_EN
      chk("t6_sat", trapCNT, 3);
`else
      chk("t6_zero", trapCNT, 0);
`endif
      for (int i = 0; i < 300; i++) begin
         rst_n      = ($urandom_range(0, 49) != 0);
         setTRAP1   = ($urandom_range(0, 3) == 0);
         setTRAP2   = ($urandom_range(0, 3) == 0);
         loadFLAGS  = ($urandom_range(0, 9) == 0);
         flagsIN    = 2'($urandom_range(0, 3));
         flagTRAPEN = ($urandom_range(0, 7) != 0);
         consTRAPEN = ($urandom_range(0, 7) != 0);
         niBOUND    = ($urandom_range(0, 2) == 0);
         trapACK    = ($urandom_range(0, 2) == 0);
         cyc();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
